// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access controller: clears the array after reset, then
// serves one host read or write at a time with registered SRAM controls.
module sram_access_ctrl #(
    parameter int unsigned DAT  = 4,
    parameter int unsigned DPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(DPTH)-1:0]  req_addr,
    input  logic [DAT-1:0]           req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DAT-1:0]           resp_rdata,
    output logic                     init_done,
    output logic                     mem_WE,
    output logic                     mem_RD,
    output logic [$clog2(DPTH)-1:0]  mem_Addr,
    output logic [DAT-1:0]           mem_dataIn,
    input  logic [DAT-1:0]           mem_dataOut
);

    localparam int unsigned AW = $clog2(DPTH);

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        WR    = 3'd2,
        RD    = 3'd3,
        RCAP  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [DAT-1:0]  wdata_nxt;
    logic [DAT-1:0]  rdata_nxt;

    // Next state plus next values of every registered output
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = mem_Addr;
        wdata_nxt = mem_dataIn;
        rdata_nxt = resp_rdata;
        case (state)
            CLEAR: begin
                if (cnt == AW'(DPTH - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    state_nxt = req_we ? WR : RD;
                end
            end
            WR:   state_nxt = IDLE;
            RD:   state_nxt = RCAP;
            RCAP: begin
                rdata_nxt = mem_dataOut;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
        // Clearing drives the counter onto the address bus with zero data
        if (state_nxt == CLEAR) begin
            addr_nxt  = cnt_nxt;
            wdata_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            mem_WE     <= 1'b1;
            mem_RD     <= 1'b0;
            mem_Addr   <= '0;
            mem_dataIn <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mem_WE     <= (state_nxt == CLEAR) || (state_nxt == WR);
            mem_RD     <= (state_nxt == RD);
            mem_Addr   <= addr_nxt;
            mem_dataIn <= wdata_nxt;
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
            resp_rdata <= rdata_nxt;
            init_done  <= (state_nxt != CLEAR);
        end
    end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter DAT, default 4: data word width in bits.
REQ-002 SHALL have parameter DPTH, default 4: number of SRAM words; address width AW = $clog2(DPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: host request present.
REQ-006 SHALL have port req_ready, output, 1: controller accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 = write request, 0 = read request.
REQ-008 SHALL have port req_addr, input, AW: request address.
REQ-009 SHALL have port req_wdata, input, DAT: write data.
REQ-010 SHALL have port resp_valid, output, 1: read data available.
REQ-011 SHALL have port resp_ready, input, 1: host consumes read data.
REQ-012 SHALL have port resp_rdata, output, DAT: read data.
REQ-013 SHALL have port init_done, output, 1: post-reset clear sequence complete.
REQ-014 SHALL have port mem_WE, output, 1: SRAM write enable.
REQ-015 SHALL have port mem_RD, output, 1: SRAM read enable.
REQ-016 SHALL have port mem_Addr, output, AW: SRAM address.
REQ-017 SHALL have port mem_dataIn, output, DAT: SRAM write data.
REQ-018 SHALL have port mem_dataOut, input, DAT: SRAM read data, registered by the SRAM on the edge where mem_RD=1 and mem_WE=0.

Function
REQ-019 SHALL implement states CLEAR, IDLE, WR, RD, RCAP, RESP.
REQ-020 SHALL, in CLEAR, hold mem_WE=1, mem_RD=0, mem_dataIn=0, mem_Addr=clear counter; the counter increments each cycle from 0 and moves to IDLE after the cycle with counter = DPTH-1, i.e. exactly DPTH cycles.
REQ-021 SHALL drive init_done=0 in CLEAR and 1 in every other state.
REQ-022 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1.
REQ-023 SHALL, on acceptance, latch req_addr into mem_Addr and req_wdata into mem_dataIn, then go to WR if req_we=1, else RD.
REQ-024 SHALL, in WR, drive mem_WE=1 and mem_RD=0 for exactly one cycle, then return to IDLE; write commits on the edge ending WR.
REQ-025 SHALL, in RD, drive mem_RD=1 and mem_WE=0 for exactly one cycle, then go to RCAP.
REQ-026 SHALL, in RCAP, drive mem_RD=0 and mem_WE=0, register mem_dataOut into resp_rdata on the edge ending RCAP, then go to RESP.
REQ-027 SHALL, in RESP, hold resp_valid=1 and resp_rdata stable until an edge with resp_ready=1, then go to IDLE.
REQ-028 SHALL drive resp_valid=1 only in RESP; read latency from the accept edge to first resp_valid cycle is 3 edges.
REQ-029 SHALL never assert mem_WE and mem_RD together, and SHALL hold mem_WE=mem_RD=0 in IDLE, RCAP and RESP.
REQ-030 SHALL decode mem_WE, mem_RD, mem_Addr, mem_dataIn, req_ready, resp_valid and init_done from registers only, with no combinational path from any input.
REQ-031 SHALL ignore req_valid outside IDLE; the host must hold the request until accepted.
REQ-032 SHALL keep mem_Addr and mem_dataIn unchanged in IDLE, holding their last values.
REQ-033 SHALL, if resp_ready=1 on the edge entering RESP, still present resp_valid for at least one cycle.

Reset
REQ-034 SHALL, on any edge with rst=1 and from any state, enter CLEAR with clear counter=0, resp_valid=0, req_ready=0, init_done=0, resp_rdata=0, mem_RD=0.
REQ-035 SHALL, on reset mid-operation in WR, RD, RCAP or RESP, abandon the transaction with no response issued, and restart the full clear sequence.
REQ-036 SHALL restart the clear sequence from address 0 when reset occurs during CLEAR.

Verification
REQ-037 SHALL pass: rst high 1 cycle, then low -> mem_WE=1 with mem_Addr 0,1,2,3 and mem_dataIn=0 on 4 consecutive cycles, then init_done=1 and req_ready=1.
REQ-038 SHALL pass: write addr 2 data 4'hA, then read addr 2 with resp_ready=1 -> resp_valid pulses once with resp_rdata=4'hA, 3 edges after read accept.
REQ-039 SHALL pass: read addr 1 after init with no prior write -> resp_rdata=4'h0.
REQ-040 SHALL pass: read addr 3 holding 4'h5 with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata=4'h5 stay stable, req_ready=0 throughout, then IDLE one edge after resp_ready=1.
REQ-041 SHALL pass: back-to-back writes with req_valid held high to addr 0 (4'h1) and addr 3 (4'hF) -> accepts every 2nd cycle, and mem_WE and mem_RD are never high together.
REQ-042 SHALL pass: rst asserted during RCAP -> no resp_valid, CLEAR restarts at addr 0, and a subsequent read of any address returns 4'h0.
